// File: rtl/can_tx_sched_pkg.sv
// can_pkg: shared frame-field widths and the scheduler state encoding
// Ports: none (package); imported by can_tx_sched, can_tx_arb and can_tx_sched_if.
package can_pkg;
  localparam int CAN_ID_W   = 29;
  localparam int CAN_DLC_W  = 4;
  localparam int CAN_DATA_W = 64;
  typedef enum logic [2:0] {IDLE, ARB, START, WAIT_BUSY, BUSY, EVAL} state_t;
endpackage

// File: rtl/can_tx_sched_if.sv
// can_tx_sched_if: mailbox and transmitter signals of the CAN transmit scheduler
// Ports: none; master = scheduler view (mailbox/tx status in, pulses/frame out),
// slave = mailbox owner plus transmitter view.
interface can_tx_sched_if #(parameter int N_MB = 4);
  logic [N_MB-1:0]                       mb_req_i;
  logic [N_MB*can_pkg::CAN_ID_W-1:0]     mb_id_i;
  logic [N_MB*can_pkg::CAN_DLC_W-1:0]    mb_dlc_i;
  logic [N_MB*can_pkg::CAN_DATA_W-1:0]   mb_data_i;
  logic [N_MB-1:0]                       mb_done_o;
  logic [N_MB-1:0]                       mb_err_o;
  logic                                  tx_start_o;
  logic [can_pkg::CAN_ID_W-1:0]          tx_id_o;
  logic [can_pkg::CAN_DLC_W-1:0]         tx_dlc_o;
  logic [can_pkg::CAN_DATA_W-1:0]        tx_data_o;
  logic                                  tx_busy_i;
  logic                                  tx_lost_i;
  logic                                  tx_acknowledged_i;
  logic                                  sched_busy_o;
  modport master (
    input  mb_req_i, mb_id_i, mb_dlc_i, mb_data_i, tx_busy_i, tx_lost_i, tx_acknowledged_i,
    output mb_done_o, mb_err_o, tx_start_o, tx_id_o, tx_dlc_o, tx_data_o, sched_busy_o
  );
  modport slave (
    output mb_req_i, mb_id_i, mb_dlc_i, mb_data_i, tx_busy_i, tx_lost_i, tx_acknowledged_i,
    input  mb_done_o, mb_err_o, tx_start_o, tx_id_o, tx_dlc_o, tx_data_o, sched_busy_o
  );
endinterface

// File: rtl/can_tx_sched_arb.sv
// can_tx_arb: combinational lowest-identifier mailbox selector
// Ports: i_req requesting mailboxes, i_id packed identifiers,
// o_grant winning index, o_valid at least one request present.
module can_tx_arb
  import can_pkg::*;
#(
  parameter int N_MB = 4,
  parameter int GW   = $clog2(N_MB)
) (
  input  logic [N_MB-1:0]          i_req,
  input  logic [N_MB*CAN_ID_W-1:0] i_id,
  output logic [GW-1:0]            o_grant,
  output logic                     o_valid
);
  logic [CAN_ID_W-1:0] w_best;
  // strict less-than keeps the lower index on equal identifiers
  always_comb begin
    o_grant = '0;
    o_valid = 1'b0;
    w_best  = '0;
    for (int k = 0; k < N_MB; k++)
      if (i_req[k] && (!o_valid || i_id[k*CAN_ID_W +: CAN_ID_W] < w_best)) begin
        o_grant = GW'(k);
        o_valid = 1'b1;
        w_best  = i_id[k*CAN_ID_W +: CAN_ID_W];
      end
  end
endmodule

// File: rtl/can_tx_sched.sv
// can_tx_sched: picks the lowest-ID pending mailbox and sequences it through the CAN transmitter
// Ports: clk_i clock, rst_i async active-low reset, bus (can_tx_sched_if.master) mailbox
// requests/fields in, done/err pulses out, start strobe and frame fields to the transmitter.
// Build option: define CAN_TX_SCHED_RETRY_EN to retry lost frames up to MAX_RETRY attempts;
// otherwise every lost frame errors at once.
module can_tx_sched
  import can_pkg::*;
#(
  parameter int N_MB      = 4,
  parameter int MAX_RETRY = 8,
  parameter int START_TMO = 15
) (
  input logic             clk_i,
  input logic             rst_i,
  can_tx_sched_if.master  bus
);
  localparam int GW = $clog2(N_MB);
  localparam int TW = $clog2(START_TMO + 1);
  state_t                r_state, w_next;
  logic [GW-1:0]         r_grant, w_grant;
  logic                  w_valid, w_limit;
  logic [TW-1:0]         r_tmo;
  logic [N_MB-1:0]       r_mask, w_req, w_done, w_err;
  logic [CAN_ID_W-1:0]   r_id;
  logic [CAN_DLC_W-1:0]  r_dlc;
  logic [CAN_DATA_W-1:0] r_data;
  if (N_MB < 2 || N_MB > 8 || MAX_RETRY < 1 || MAX_RETRY > 15 || START_TMO < 1) begin : g_bad_param
    $error("can_tx_sched: parameter out of range");
  end
  // a mailbox that just pulsed cannot start a new arbitration in the following cycle
  assign w_req = bus.mb_req_i & ~r_mask;
  can_tx_arb #(.N_MB(N_MB)) u_arb (
    .i_req   (w_req),
    .i_id    (bus.mb_id_i),
    .o_grant (w_grant),
    .o_valid (w_valid)
  );
`ifdef CAN_TX_SCHED_RETRY_EN
  logic [3:0] r_retry;
  // true when the attempt being evaluated is the last one allowed
  assign w_limit = r_retry == 4'(MAX_RETRY - 1);
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) r_retry <= '0;
    else if (r_state == ARB && w_valid && w_grant != r_grant) r_retry <= '0;
    else if (r_state == EVAL) r_retry <= (bus.tx_acknowledged_i || w_limit) ? '0 : r_retry + 4'd1;
    else if (|w_err) r_retry <= '0;
`else
  assign w_limit = 1'b1;
`endif
  always_comb begin
    w_next = r_state;
    w_done = '0;
    w_err  = '0;
    case (r_state)
      IDLE:      w_next = |w_req ? ARB : IDLE;
      ARB:       w_next = w_valid ? START : IDLE;
      START:     w_next = WAIT_BUSY;
      WAIT_BUSY: if (bus.tx_busy_i) w_next = BUSY;
                 else if (r_tmo == TW'(START_TMO - 1)) begin
                   w_next         = IDLE;
                   w_err[r_grant] = 1'b1;
                 end
      BUSY:      w_next = bus.tx_busy_i ? BUSY : EVAL;
      EVAL: begin
        w_next          = IDLE;
        w_done[r_grant] = bus.tx_acknowledged_i;
        w_err[r_grant]  = !bus.tx_acknowledged_i && w_limit;
      end
      default:   w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_tmo   <= '0;
      r_mask  <= '0;
      r_id    <= '0;
      r_dlc   <= '0;
      r_data  <= '0;
    end else begin
      r_state <= w_next;
      r_mask  <= w_done | w_err;
      r_tmo   <= (r_state == WAIT_BUSY) ? r_tmo + 1'b1 : '0;
      if (r_state == ARB && w_valid) begin
        r_grant <= w_grant;
        r_id    <= bus.mb_id_i[w_grant*CAN_ID_W +: CAN_ID_W];
        r_dlc   <= bus.mb_dlc_i[w_grant*CAN_DLC_W +: CAN_DLC_W];
        r_data  <= bus.mb_data_i[w_grant*CAN_DATA_W +: CAN_DATA_W];
      end
    end
  assign bus.mb_done_o    = w_done;
  assign bus.mb_err_o     = w_err;
  assign bus.tx_start_o   = r_state == START;
  assign bus.sched_busy_o = r_state != IDLE;
  assign bus.tx_id_o      = r_id;
  assign bus.tx_dlc_o     = r_dlc;
  assign bus.tx_data_o    = r_data;
endmodule

// File: doc/can_tx_sched.md
CAN_TX_SCHED -- requirements
Module: can_tx_sched

Interface
REQ-001 Clocking and reset: one clock; reset is asynchronous and active-low.
REQ-002 Parameter N_MB, 4, number of transmit mailboxes (2..8).
REQ-003 Parameter MAX_RETRY, 8, lost-arbitration retries per frame before error (1..15).
REQ-004 Parameter START_TMO, 15, cycles allowed from tx_start_o to tx_busy_i high.
REQ-005 clk_i  input  1  CAN bit-rate clock (same clock as the transmitter).
REQ-006 rst_i  input  1  asynchronous reset, active low.
REQ-007 mb_req_i  input  N_MB  per-mailbox transmit request, level, held until done/err.
REQ-008 mb_id_i  input  N_MB*29  extended identifier per mailbox; mailbox k in bits [29k+28:29k].
REQ-009 mb_dlc_i  input  N_MB*4  DLC per mailbox.
REQ-010 mb_data_i  input  N_MB*64  payload per mailbox.
REQ-011 mb_done_o  output  N_MB  one-cycle pulse: frame acknowledged.
REQ-012 mb_err_o  output  N_MB  one-cycle pulse: retry limit or start timeout.
REQ-013 tx_start_o  output  1  one-cycle start strobe to the transmitter.
REQ-014 tx_id_o, tx_dlc_o, tx_data_o  output  29/4/64  frame fields to the transmitter.
REQ-015 tx_busy_i, tx_lost_i, tx_acknowledged_i  input  1 each  transmitter status.
REQ-016 sched_busy_o  output  1  high in every state except IDLE.

Function
REQ-017 FSM states IDLE, ARB, START, WAIT_BUSY, BUSY, EVAL.
- IDLE->ARB when any mb_req_i bit is high.
- ARB (1 cycle): register the grant index and that mailbox's id/dlc/data.
- ARB->START->WAIT_BUSY: tx_start_o is high for exactly the START cycle.
- WAIT_BUSY->BUSY on tx_busy_i=1.
- BUSY->EVAL on tx_busy_i=0.
- EVAL->IDLE.
REQ-018 Arbitration: the requesting mailbox with the numerically lowest mb_id_i wins; on an equal ID the lowest index wins.
REQ-019 tx_id_o/tx_dlc_o/tx_data_o SHALL stay stable from START until EVAL, regardless of changes on the mailbox inputs.
REQ-020 EVAL with tx_acknowledged_i=1: pulse mb_done_o[grant] and clear the retry count; tx_acknowledged_i takes priority over tx_lost_i if both are high.
REQ-021 EVAL with tx_lost_i=1: increment the retry count; if the count reaches MAX_RETRY, pulse mb_err_o[grant] and clear the count; otherwise return to IDLE and re-arbitrate, with no pulse.
REQ-022 EVAL with neither tx_acknowledged_i nor tx_lost_i high: treat as lost.
REQ-023 WAIT_BUSY lasting START_TMO cycles without tx_busy_i: pulse mb_err_o[grant] and go to IDLE.
REQ-024 If mb_req_i[grant] drops mid-frame, the frame completes and the done/err pulse is still issued.
REQ-025 The retry count tracks the last granted mailbox only; a grant to a different mailbox resets it to 0.
REQ-026 A mailbox is not re-granted in the cycle after its own done/err pulse.

Reset
REQ-027 Reset SHALL immediately force IDLE and set all outputs and the retry count to 0, including mid-frame.

Configuration
REQ-028 Macro CAN_TX_SCHED_RETRY_EN.
- Defined: retry behaviour per REQ-021.
- Undefined: any lost frame immediately pulses mb_err_o and no retry counter is synthesised.

Structure
REQ-029 Package can_pkg holds the FSM state enum, CAN_ID_W=29, CAN_DLC_W=4 and CAN_DATA_W=64.
REQ-030 Sub-module can_tx_arb: combinational lowest-ID selector producing a grant index and a valid flag.

Verification
REQ-031 Requests on mb 0 (id 0x100) and mb 2 (id 0x050) in the same cycle -> mb 2 granted first; tx_id_o=0x050; mb 0 follows after mb_done_o[2].
REQ-032 Equal ids 0x200 on mb 1 and mb 3 -> mb 1 granted first.
REQ-033 tx_lost_i on 3 attempts, then ack -> 4 tx_start_o pulses, then a single mb_done_o pulse.
REQ-034 tx_lost_i on every attempt with MAX_RETRY=8 -> 8 starts, then mb_err_o; without the macro -> 1 start, then mb_err_o.
REQ-035 tx_busy_i never rises -> mb_err_o pulses 15 cycles after tx_start_o.
REQ-036 rst_i low during BUSY -> tx_start_o, sched_busy_o and the pulses are 0 immediately, and the FSM is in IDLE on release.
